out_channel_arbiter: RTL and testbench

//  Shares the single program out channel between NReq producers (VM instances/test units).

---
 rtl/out_channel_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/out_channel_arbiter.sv | 166 ++++++++++++++++
 tb/tb_out_channel_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_channel_pkg.sv
// out_channel_pkg
//   Shared types and helpers for the program out-channel arbiter.
//   - DefaultMemoryElementWidth : default width of one channel word
//   - oc_state_t                : arbiter lifecycle (ACCEPT, DRAIN, DONE)
//   - rr_next                   : round-robin successor of a producer index
package out_channel_pkg;

  localparam int DefaultMemoryElementWidth = 12;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } oc_state_t;

  // Next producer index after ptr, wrapping at n without assuming n is a power of 2
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker. Searches req starting at rrPtr,
//   then rrPtr+1, ... (mod NReq) and grants the first set bit.
//   Ports:
//     req    in   NReq          request vector
//     rrPtr  in   $clog2(NReq)  index that has top priority this cycle
//     gnt    out  NReq          one-hot grant (all zero when no request)
//     g      out  $clog2(NReq)  encoded index of the granted request
//     any    out  1             at least one request was granted
module rr_arbiter #(
  parameter int NReq = 4
) (
  input  logic [NReq-1:0]         req,
  input  logic [$clog2(NReq)-1:0] rrPtr,
  output logic [NReq-1:0]         gnt,
  output logic [$clog2(NReq)-1:0] g,
  output logic                    any
);

  localparam int IdxW = $clog2(NReq);

  // One extra bit so rrPtr+k never wraps before the explicit modulo below
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;

  // Walk the requests in priority order starting from rrPtr; the first hit
  // wins and later hits are ignored through the any flag.
  always_comb begin
    gnt = '0;
    g   = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NReq; k++) begin
      sum = {1'b0, rrPtr} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NReq)) begin
        sum = sum - (IdxW+1)'(NReq);
      end
      idx = sum[IdxW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        g        = idx;
      end
    end
  end

endmodule

// File: rtl/out_channel_arbiter.sv
// out_channel_arbiter
//   Shares the single program out channel between NReq producers. One valid
//   producer per cycle is picked round-robin and its word is written into an
//   NOut-deep circular buffer that a consumer drains over valid/ready. A finish
//   request stops intake, lets the buffer drain, then raises finished.
//   Optional feature macro: OUT_CHANNEL_OVERWRITE_EN
//     defined   : grants ignore full; a write into a full buffer that is not
//                 being drained drops the oldest word and bumps overflows.
//     undefined : full blocks all grants; overflows is tied to 0.
//   Ports:
//     clock       in   1               single clock, all state on posedge
//     reset       in   1               asynchronous, active-high
//     reqValid    in   NReq            producer i has a word
//     reqData     in   NReq*W          producer i word at [i*W +: W]
//     reqReady    out  NReq            one-hot grant, word accepted this cycle
//     drainValid  out  1               buffer non-empty
//     drainData   out  W               oldest word (0 when empty)
//     drainReady  in   1               consumer takes drainData
//     finish      in   1               request end of program
//     count       out  $clog2(NOut+1)  words held
//     full        out  1               count == NOut
//     empty       out  1               count == 0
//     finished    out  1               drain after finish complete
//     overflows   out  16              words lost to overwrite (saturating)
module out_channel_arbiter
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NReq               = 4,
  parameter int NOut               = 9
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NReq-1:0]                  reqValid,
  input  logic [NReq*MemoryElementWidth-1:0] reqData,
  output logic [NReq-1:0]                  reqReady,
  output logic                             drainValid,
  output logic [MemoryElementWidth-1:0]    drainData,
  input  logic                             drainReady,
  input  logic                             finish,
  output logic [$clog2(NOut+1)-1:0]        count,
  output logic                             full,
  output logic                             empty,
  output logic                             finished,
  output logic [15:0]                      overflows
);

  localparam int W      = MemoryElementWidth;
  localparam int PtrW   = $clog2(NOut);
  localparam int IdxW   = $clog2(NReq);

  oc_state_t       state;
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [IdxW-1:0] rrPtr;
  logic [W-1:0]    mem [NOut];

  logic [NReq-1:0] arbGnt;
  logic [IdxW-1:0] arbIdx;
  logic            arbAny;
  logic            canGrant;
  logic            wrEn;
  logic            rdEn;
  logic            dropOldest;
  logic [W-1:0]    wrWord;

  // Pointer successor with an explicit compare so non power-of-2 depths wrap correctly
  function automatic logic [PtrW-1:0] ptrNext(input logic [PtrW-1:0] p);
    return (p == PtrW'(NOut - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(.NReq(NReq)) uArb (
    .req   (reqValid),
    .rrPtr (rrPtr),
    .gnt   (arbGnt),
    .g     (arbIdx),
    .any   (arbAny)
  );

  assign full       = (count == ($clog2(NOut+1))'(NOut));
  assign empty      = (count == '0);
  assign drainValid = !empty;
  assign drainData  = empty ? '0 : mem[head];
  assign finished   = (state == DONE);

  // Grants only happen while accepting and never in the cycle finish is seen.
  // Reset also masks grants so reqReady reads 0 while reset is held. Without
  // overwrite, full blocks grants regardless of drainReady so there is no
  // combinational path from the consumer back to the producers.
  always_comb begin
    canGrant = !reset && (state == ACCEPT) && !finish;
`ifndef OUT_CHANNEL_OVERWRITE_EN
    canGrant = canGrant && !full;
`endif
  end

  assign reqReady = {NReq{canGrant}} & arbGnt;
  assign wrEn     = canGrant && arbAny;
  assign rdEn     = drainValid && drainReady;
  assign wrWord   = reqData[arbIdx*W +: W];

`ifdef OUT_CHANNEL_OVERWRITE_EN
  logic [15:0] ovCount;

  assign dropOldest = wrEn && full && !rdEn;
  assign overflows  = ovCount;

  // Count words lost when a write lands on a full buffer nobody is draining
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovCount <= '0;
    end else if (dropOldest && (ovCount != 16'hFFFF)) begin
      ovCount <= ovCount + 1'b1;
    end
  end
`else
  assign dropOldest = 1'b0;
  assign overflows  = '0;
`endif

  // Storage has no reset; drainData is masked while empty so stale words never leak
  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[tail] <= wrWord;
    end
  end

  // Pointers, occupancy and round-robin priority. Head also advances when an
  // overwrite drops the oldest word, keeping count pinned at NOut.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rrPtr <= '0;
    end else begin
      if (wrEn) begin
        tail  <= ptrNext(tail);
        rrPtr <= IdxW'(rr_next(int'(arbIdx), NReq));
      end
      if (rdEn || dropOldest) begin
        head <= ptrNext(head);
      end
      if (wrEn && !rdEn && !full) begin
        count <= count + 1'b1;
      end else if (!wrEn && rdEn) begin
        count <= count - 1'b1;
      end
    end
  end

  // Lifecycle: finish moves to DRAIN, an empty buffer with no write pending
  // moves to DONE, and DONE is only left through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ACCEPT;
    end else begin
      case (state)
        ACCEPT:  if (finish) state <= DRAIN;
        DRAIN:   if ((count == '0) && !wrEn) state <= DONE;
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_arbiter.sv
// tb_out_channel_arbiter
//   Self-checking bench for out_channel_arbiter (NReq=4, NOut=9, W=12).
//   A queue-based reference model tracks buffered words, round-robin priority,
//   lifecycle state and overflow count; directed scenarios plus a randomized
//   run are compared against it. Honours OUT_CHANNEL_OVERWRITE_EN.
module tb_out_channel_arbiter;

  localparam int W    = 12;
  localparam int NReq = 4;
  localparam int NOut = 9;

`ifdef OUT_CHANNEL_OVERWRITE_EN
  localparam bit OvEn = 1'b1;
`else
  localparam bit OvEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NReq-1:0]   reqValid = '0;
  logic [NReq*W-1:0] reqData = '0;
  logic [NReq-1:0]   reqReady;
  logic              drainValid;
  logic [W-1:0]      drainData;
  logic              drainReady = 1'b0;
  logic              finish = 1'b0;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              finished;
  logic [15:0]       overflows;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mq[$];
  int mRr;
  int mState;
  int mOv;

  // Expected outputs for the current cycle
  int          expIdx;
  logic [3:0]  expReady;
  logic        expValid;
  logic [W-1:0] expData;
  int          expCount;
  logic        expFull;
  logic        expEmpty;
  logic        expFinished;
  logic [15:0] expOv;

  out_channel_arbiter #(
    .MemoryElementWidth(W),
    .NReq(NReq),
    .NOut(NOut)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .drainValid (drainValid),
    .drainData  (drainData),
    .drainReady (drainReady),
    .finish     (finish),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .finished   (finished),
    .overflows  (overflows)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [NReq*W-1:0] d,
                               input logic dr, input logic fin);
    reqValid   = v;
    reqData    = d;
    drainReady = dr;
    finish     = fin;
  endtask

  task automatic modelReset();
    mq.delete();
    mRr    = 0;
    mState = 0;
    mOv    = 0;
  endtask

  task automatic computeExpected();
    int i;
    expIdx = -1;
    if (!reset && mState == 0 && !finish && (OvEn || mq.size() < NOut)) begin
      for (int k = 0; k < NReq; k++) begin
        i = (mRr + k) % NReq;
        if (expIdx < 0 && reqValid[i]) expIdx = i;
      end
    end
    expReady    = (expIdx >= 0) ? 4'(1 << expIdx) : 4'b0000;
    expValid    = (mq.size() > 0);
    expData     = expValid ? W'(mq[0]) : '0;
    expCount    = mq.size();
    expFull     = (mq.size() == NOut);
    expEmpty    = (mq.size() == 0);
    expFinished = (mState == 2);
    expOv       = 16'(mOv);
  endtask

  // Advance the model by one clock with the current inputs, then move to the next negedge
  task automatic tick();
    int sizeBefore;
    computeExpected();
    sizeBefore = mq.size();
    if (expValid && drainReady) void'(mq.pop_front());
    if (expIdx >= 0) begin
      mq.push_back(int'(reqData[expIdx*W +: W]));
      mRr = (expIdx + 1) % NReq;
      if (mq.size() > NOut) begin
        void'(mq.pop_front());
        if (mOv < 65535) mOv++;
      end
    end
    if (mState == 0 && finish) mState = 1;
    else if (mState == 1 && sizeBefore == 0) mState = 2;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    modelReset();
    reset = 1'b1;
    applyStimulus(4'hF, '0, 1'b0, 1'b0);
    #2;
    checks++;
    if (reqReady !== 4'b0000) begin failures++; $display("FAIL reset_reqReady: got %b want 0000", reqReady); end
    checks++;
    if (drainValid !== 1'b0 || drainData !== '0) begin failures++; $display("FAIL reset_drain: got valid=%b data=%0d want 0/0", drainValid, drainData); end
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL reset_level: got full=%b empty=%b count=%0d want 0/1/0", full, empty, count); end
    checks++;
    if (finished !== 1'b0 || overflows !== 16'd0) begin failures++; $display("FAIL reset_status: got finished=%b overflows=%0d want 0/0", finished, overflows); end
    applyStimulus('0, '0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0]        v;
    logic [NReq*W-1:0] d;
    doReset();
    v = 4'b0111;
    d = '0;
    d[0*W +: W] = 12'd1;
    d[1*W +: W] = 12'd2;
    d[2*W +: W] = 12'd3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v, d, 1'b0, 1'b0);
      #1;
      checks++;
      if (reqReady !== 4'(1 << i)) begin failures++; $display("FAIL basic_grant%0d: got %b want %b", i, reqReady, 4'(1 << i)); end
      tick();
      v[i] = 1'b0;
    end
    applyStimulus('0, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== 4'd3) begin failures++; $display("FAIL basic_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, d, 1'b1, 1'b0);
      #1;
      checks++;
      if (drainValid !== 1'b1 || drainData !== 12'(i + 1)) begin failures++; $display("FAIL basic_drain%0d: got valid=%b data=%0d want 1/%0d", i, drainValid, drainData, i + 1); end
      tick();
    end
    #1;
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty: got %b want 1", empty); end
  endtask

  task automatic test_round_robin();
    logic [NReq*W-1:0] d;
    doReset();
    for (int i = 0; i < NReq; i++) d[i*W +: W] = 12'h100 + 12'(i);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'hF, d, 1'b1, 1'b0);
      #1;
      checks++;
      if (reqReady !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", c, reqReady, 4'(1 << (c % 4))); end
      if (c > 0) begin
        checks++;
        if (drainData !== 12'h100 + 12'((c - 1) % 4)) begin failures++; $display("FAIL rr_data%0d: got %h want %h", c, drainData, 12'h100 + 12'((c - 1) % 4)); end
      end
      tick();
    end
    applyStimulus('0, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== 4'd1) begin failures++; $display("FAIL rr_count: got %0d want 1", count); end
  endtask

  task automatic test_full();
    logic [NReq*W-1:0] d;
    doReset();
    d = '0;
    for (int i = 0; i < NOut; i++) begin
      d[0 +: W] = 12'(10 + i);
      applyStimulus(4'b0001, d, 1'b0, 1'b0);
      tick();
    end
    #1;
    checks++;
    if (count !== 4'd9 || full !== 1'b1) begin failures++; $display("FAIL full_fill: got count=%0d full=%b want 9/1", count, full); end
    d[0 +: W] = 12'd99;
    applyStimulus(4'b0001, d, 1'b0, 1'b0);
    #1;
`ifdef OUT_CHANNEL_OVERWRITE_EN
    checks++;
    if (reqReady !== 4'b0001) begin failures++; $display("FAIL full_ovgrant: got %b want 0001", reqReady); end
    tick();
    applyStimulus('0, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (overflows !== 16'd1 || drainData !== 12'd11 || count !== 4'd9) begin failures++; $display("FAIL full_ovresult: got ov=%0d data=%0d count=%0d want 1/11/9", overflows, drainData, count); end
`else
    checks++;
    if (reqReady !== 4'b0000 || full !== 1'b1) begin failures++; $display("FAIL full_block: got reqReady=%b full=%b want 0000/1", reqReady, full); end
    tick();
    applyStimulus('0, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (drainData !== 12'd10 || count !== 4'd9) begin failures++; $display("FAIL full_hold: got data=%0d count=%0d want 10/9", drainData, count); end
`endif
  endtask

  task automatic test_overwrite_wrap();
    logic [NReq*W-1:0] d;
    int n;
    doReset();
    for (int c = 0; c < 21; c++) begin
      for (int i = 0; i < NReq; i++) d[i*W +: W] = W'($urandom);
      applyStimulus(4'($urandom_range(1, 15)), d, (c >= NOut), 1'b0);
      #1;
      computeExpected();
      checks++;
      if (reqReady !== expReady || drainData !== expData || count !== 4'(expCount)) begin
        failures++;
        $display("FAIL wrap_cycle%0d: got rdy=%b data=%0d count=%0d want %b/%0d/%0d", c, reqReady, drainData, count, expReady, expData, expCount);
      end
      tick();
    end
    n = 0;
    while (mq.size() > 0 && n < 2 * NOut) begin
      applyStimulus('0, d, 1'b1, 1'b0);
      #1;
      computeExpected();
      checks++;
      if (drainValid !== 1'b1 || drainData !== expData) begin failures++; $display("FAIL wrap_drain%0d: got valid=%b data=%0d want 1/%0d", n, drainValid, drainData, expData); end
      tick();
      n++;
    end
    applyStimulus('0, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_finish();
    logic [NReq*W-1:0] d;
    int n;
    doReset();
    d = '0;
    d[1*W +: W] = 12'd5;
    applyStimulus(4'b0010, d, 1'b0, 1'b0);
    tick();
    d[1*W +: W] = 12'd6;
    applyStimulus(4'b0010, d, 1'b0, 1'b0);
    tick();
    applyStimulus(4'hF, d, 1'b0, 1'b1);
    #1;
    checks++;
    if (reqReady !== 4'b0000 || count !== 4'd2) begin failures++; $display("FAIL finish_wins: got rdy=%b count=%0d want 0000/2", reqReady, count); end
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'hF, d, 1'b1, 1'b0);
      #1;
      checks++;
      if (reqReady !== 4'b0000 || drainData !== 12'(5 + i)) begin failures++; $display("FAIL finish_drain%0d: got rdy=%b data=%0d want 0000/%0d", i, reqReady, drainData, 5 + i); end
      tick();
    end
    n = 0;
    while (finished !== 1'b1 && n < 4) begin
      applyStimulus(4'hF, d, 1'b1, 1'b0);
      tick();
      n++;
    end
    #1;
    checks++;
    if (finished !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL finish_done: got finished=%b empty=%b after %0d cycles want 1/1", finished, empty, n); end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'hF, d, 1'b1, 1'b0);
      #1;
      checks++;
      if (finished !== 1'b1 || reqReady !== 4'b0000) begin failures++; $display("FAIL finish_hold%0d: got finished=%b rdy=%b want 1/0000", c, finished, reqReady); end
      tick();
    end
  endtask

  task automatic test_reset_midfill();
    logic [NReq*W-1:0] d;
    doReset();
    for (int i = 0; i < NReq; i++) d[i*W +: W] = 12'h200 + 12'(i);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'hF, d, 1'b0, 1'b0);
      tick();
    end
    #1;
    checks++;
    if (count !== 4'd5) begin failures++; $display("FAIL midreset_fill: got %0d want 5", count); end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || drainValid !== 1'b0 || finished !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL midreset_async: got empty=%b valid=%b finished=%b count=%0d want 1/0/0/0", empty, drainValid, finished, count);
    end
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'hF, d, 1'b0, 1'b0);
    #1;
    checks++;
    if (reqReady !== 4'b0001) begin failures++; $display("FAIL midreset_grant: got %b want 0001", reqReady); end
    tick();
    #1;
    checks++;
    if (drainData !== 12'h200 || count !== 4'd1) begin failures++; $display("FAIL midreset_word: got data=%h count=%0d want 200/1", drainData, count); end
  endtask

  task automatic test_random();
    logic [NReq*W-1:0] d;
    doReset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0 || (mState == 2 && $urandom_range(0, 3) == 0)) doReset();
      for (int i = 0; i < NReq; i++) d[i*W +: W] = W'($urandom);
      applyStimulus(4'($urandom_range(0, 15)), d, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
      #1;
      computeExpected();
      checks++;
      if (reqReady !== expReady) begin failures++; $display("FAIL rand_reqReady c%0d: got %b want %b", c, reqReady, expReady); end
      checks++;
      if (drainValid !== expValid || drainData !== expData) begin failures++; $display("FAIL rand_drain c%0d: got %b/%0d want %b/%0d", c, drainValid, drainData, expValid, expData); end
      checks++;
      if (count !== 4'(expCount) || full !== expFull || empty !== expEmpty) begin failures++; $display("FAIL rand_level c%0d: got %0d/%b/%b want %0d/%b/%b", c, count, full, empty, expCount, expFull, expEmpty); end
      checks++;
      if (finished !== expFinished || overflows !== expOv) begin failures++; $display("FAIL rand_status c%0d: got %b/%0d want %b/%0d", c, finished, overflows, expFinished, expOv); end
      tick();
    end
  endtask

  initial begin
    $display("[TB] starting out_channel_arbiter bench");
    test_reset();
    test_basic();
    test_round_robin();
    test_full();
    test_overwrite_wrap();
    test_finish();
    test_reset_midfill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
